counter_updown_mod: RTL and testbench

//   Parametrised successor to the 4-bit enable/reset counter.

---
 rtl/counter_updown_mod_if.sv | 25 ++
 rtl/counter_updown_mod.sv | 74 +++++++
 tb/tb_counter_updown_mod.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
// The master drives the step/load/clear controls; the slave returns the count and its flags.
interface counter_updown_mod_if #(
  parameter int WIDTH = 4
);
  logic             enable;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             ovf_sticky;

  modport master (
    output enable, up_dn, clear, load, load_val,
    input  count, tc, wrap, ovf_sticky
  );

  modport slave (
    input  enable, up_dn, clear, load, load_val,
    output count, tc, wrap, ovf_sticky
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with modulus, load/clear, wrap-or-saturate mode,
// a terminal-count decode, a one-cycle wrap pulse and a sticky overflow flag.
module counter_updown_mod #(
  parameter int WIDTH     = 4,
  parameter int MAX_VAL   = (1 << WIDTH) - 1,
  parameter int SATURATE  = 0,
  parameter int RESET_VAL = 0
) (
  input logic                 clk,
  input logic                 reset,
  counter_updown_mod_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_limit;

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  // Value taken by a step at the limit: hold in saturate mode, jump to the far end otherwise.
  function automatic logic [WIDTH-1:0] limit_step(input logic up, input logic [WIDTH-1:0] c);
    if (SATURATE != 0) return c;
    return up ? '0 : MAX_C;
  endfunction

  // Limit compared before stepping so a non-power-of-2 modulus never overshoots.
  assign at_limit = bus.up_dn ? (count_q == MAX_C) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      count_d = RST_C;
      ovf_d   = 1'b0;
    end else if (bus.load) begin
      count_d = clamp_load(bus.load_val);
    end else if (bus.enable) begin
      if (at_limit) begin
        count_d = limit_step(bus.up_dn, count_q);
        wrap_d  = 1'b1;
        ovf_d   = 1'b1;
      end else if (bus.up_dn) begin
        count_d = count_q + WIDTH'(1);
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RST_C;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.count      = count_q;
  assign bus.tc         = at_limit;
  assign bus.wrap       = wrap_q;
  assign bus.ovf_sticky = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: three configurations (mod-10 wrap, mod-10
// saturate, 8-bit with non-zero reset value) plus a randomised run on the 8-bit one.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  logic r0, r1, r2;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  counter_updown_mod_if #(.WIDTH(4)) b0 ();
  counter_updown_mod_if #(.WIDTH(4)) b1 ();
  counter_updown_mod_if #(.WIDTH(8)) b2 ();

  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0), .RESET_VAL(0))
    u_wrap (.clk(clk), .reset(r0), .bus(b0));
  counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1), .RESET_VAL(0))
    u_sat (.clk(clk), .reset(r1), .bus(b1));
  counter_updown_mod #(.WIDTH(8), .MAX_VAL(255), .SATURATE(0), .RESET_VAL(100))
    u_w8 (.clk(clk), .reset(r2), .bus(b2));

  task automatic check_val(input string tag, input int obs, input int exp);
    vecs++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic en, input logic up, input logic clr, input logic ld,
                      input logic [3:0] lv);
    b0.enable = en; b0.up_dn = up; b0.clear = clr; b0.load = ld; b0.load_val = lv;
  endtask

  task automatic set1(input logic en, input logic up, input logic clr, input logic ld,
                      input logic [3:0] lv);
    b1.enable = en; b1.up_dn = up; b1.clear = clr; b1.load = ld; b1.load_val = lv;
  endtask

  task automatic set2(input logic en, input logic up, input logic clr, input logic ld,
                      input logic [7:0] lv);
    b2.enable = en; b2.up_dn = up; b2.clear = clr; b2.load = ld; b2.load_val = lv;
  endtask

  task automatic expect0(input string tag, input int c, input int w, input int o);
    check_val({tag, "_count"}, b0.count, c);
    check_val({tag, "_wrap"}, b0.wrap, w);
    check_val({tag, "_ovf"}, b0.ovf_sticky, o);
  endtask

  task automatic expect1(input string tag, input int c, input int w, input int o);
    check_val({tag, "_count"}, b1.count, c);
    check_val({tag, "_wrap"}, b1.wrap, w);
    check_val({tag, "_ovf"}, b1.ovf_sticky, o);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, w, o;
    int m, mw, mo;
    logic rr, en, up, clr, ld;
    logic [7:0] lv;

    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    set0(0, 0, 0, 0, 4'd0);
    set1(0, 0, 0, 0, 4'd0);
    set2(0, 0, 0, 0, 8'd0);
    tick();
    tick();
    expect0("rst0", 0, 0, 0);
    check_val("rst0_tc", b0.tc, 1);
    expect1("rst1", 0, 0, 0);
    check_val("rst2_count", b2.count, 100);
    check_val("rst2_tc", b2.tc, 0);
    r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    // Test 1: count up through the modulus-10 wrap.
    set0(1, 1, 0, 0, 4'd0);
    c = 0; o = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      w = (c == 9) ? 1 : 0;
      c = (c == 9) ? 0 : c + 1;
      if (w != 0) o = 1;
      expect0("t1", c, w, o);
    end

    // Test 3: count down through zero in wrap mode.
    set0(0, 0, 0, 1, 4'd1);
    tick();
    expect0("t3_load", 1, 0, 1);
    set0(1, 0, 0, 0, 4'd0);
    #1 check_val("t3_tc_at1", b0.tc, 0);
    tick();
    expect0("t3_dn0", 0, 0, 1);
    check_val("t3_tc_at0", b0.tc, 1);
    tick();
    expect0("t3_dn9", 9, 1, 1);
    check_val("t3_tc_at9dn", b0.tc, 0);
    b0.up_dn = 1'b1;
    #1 check_val("t3_tc_at9up", b0.tc, 1);
    b0.enable = 1'b0;
    tick();
    expect0("t3_hold", 9, 0, 1);

    // Test 4: load clamp, clear beats load, load beats enable.
    set0(0, 1, 0, 1, 4'hF);
    tick();
    expect0("t4_clamp", 9, 0, 1);
    set0(0, 1, 1, 1, 4'd5);
    tick();
    expect0("t4_clrld", 0, 0, 0);
    set0(1, 1, 0, 1, 4'd7);
    tick();
    expect0("t4_lden", 7, 0, 0);

    // Test 5: gated counting, then a mid-run reset clears flags.
    set0(0, 1, 0, 1, 4'd9);
    tick();
    set0(1, 1, 0, 0, 4'd0);
    tick();
    expect0("t5_setovf", 0, 1, 1);
    set0(0, 1, 0, 1, 4'd3);
    tick();
    expect0("t5_ld3", 3, 0, 1);
    for (int i = 0; i < 4; i++) begin
      b0.load = 1'b0;
      b0.enable = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check_val("t5_gated", b0.count, 4 + i / 2);
    end
    b0.enable = 1'b1;
    tick();
    expect0("t5_six", 6, 0, 1);
    r0 = 1'b1;
    tick();
    expect0("t5_rst", 0, 0, 0);
    r0 = 1'b0;
    set0(0, 0, 0, 0, 4'd0);

    // Test 2: saturate mode holds at both limits but still flags the event.
    set1(0, 1, 0, 1, 4'd8);
    tick();
    expect1("t2_ld8", 8, 0, 0);
    set1(1, 1, 0, 0, 4'd0);
    tick();
    expect1("t2_up9", 9, 0, 0);
    tick();
    expect1("t2_sat1", 9, 1, 1);
    tick();
    expect1("t2_sat2", 9, 1, 1);
    b1.enable = 1'b0;
    tick();
    expect1("t2_idle", 9, 0, 1);
    set1(0, 0, 1, 0, 4'd0);
    tick();
    expect1("t2_clr", 0, 0, 0);
    set1(1, 0, 0, 0, 4'd0);
    #1 check_val("t2_tc0", b1.tc, 1);
    tick();
    expect1("t2_sat0", 0, 1, 1);
    b1.enable = 1'b0;
    tick();
    expect1("t2_hold0", 0, 0, 1);

    // Test 6: 8-bit counter, full-range wrap then randomised control against a model.
    set2(0, 1, 0, 1, 8'd250);
    tick();
    check_val("t6_ld250", b2.count, 250);
    set2(1, 1, 0, 0, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("t6_up", b2.count, 251 + i);
    end
    check_val("t6_tc255", b2.tc, 1);
    tick();
    check_val("t6_wrapcnt", b2.count, 0);
    check_val("t6_wrap", b2.wrap, 1);
    check_val("t6_ovf", b2.ovf_sticky, 1);

    m = 0; mw = 1; mo = 1;
    for (int i = 0; i < 10000; i++) begin
      rr  = ($urandom_range(63) == 0);
      clr = ($urandom_range(31) == 0);
      ld  = ($urandom_range(15) == 0);
      en  = ($urandom_range(3) != 0);
      up  = $urandom_range(1);
      lv  = 8'($urandom_range(255));
      r2 = rr;
      set2(en, up, clr, ld, lv);
      #1 check_val("t6r_tc", b2.tc, up ? (m == 255) : (m == 0));
      @(posedge clk);
      if (rr || clr) begin
        m = 100; mw = 0; mo = 0;
      end else if (ld) begin
        m = int'(lv); mw = 0;
      end else if (en) begin
        if (up) begin
          mw = (m == 255) ? 1 : 0;
          m  = (m + 1) % 256;
        end else begin
          mw = (m == 0) ? 1 : 0;
          m  = (m + 255) % 256;
        end
        if (mw != 0) mo = 1;
      end else begin
        mw = 0;
      end
      #1;
      check_val("t6r_count", b2.count, m);
      check_val("t6r_wrap", b2.wrap, mw);
      check_val("t6r_ovf", b2.ovf_sticky, mo);
    end
    r2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
